// File: rtl/sha256_msg_scheduler_if.sv
// -----------------------------------------------------------------------------
// sha256_msg_scheduler_if
// Bundles the request side (message capture, start, release) and the word
// stream side (valid/ready) of the SHA-256 message scheduler.
//
// Signals:
//   start          : begin scheduling (sampled by the scheduler in IDLE only)
//   processed_msg  : padded message, block k = bits [MSG_W-1-512k -: 512]
//   num_blocks_m1  : number of blocks minus one
//   w_ready        : consumer accepts w_t this cycle
//   next_block     : consumer releases the next block
//   w_t            : schedule word W[round]
//   w_valid        : w_t valid
//   round          : index of w_t within the block
//   block_idx      : current block number
//   block_first    : round 0 of a block is on the bus
//   block_last     : current block is the final block
//   busy           : scheduler not idle
//   done           : one-cycle pulse after the final word is accepted
//   w_sum          : running mod-2^32 sum of transferred words in the block
//                    (present only when SCHED_CHKSUM_EN is defined)
//
// Modports: master = message source / word consumer, slave = scheduler.
// -----------------------------------------------------------------------------
interface sha256_msg_scheduler_if #(
    parameter int NUM_BLK_MAX = 4
);
    localparam int MSG_W  = 512 * NUM_BLK_MAX;
    localparam int BIDX_W = (NUM_BLK_MAX > 1) ? $clog2(NUM_BLK_MAX) : 1;

    logic              start;
    logic [MSG_W-1:0]  processed_msg;
    logic [BIDX_W-1:0] num_blocks_m1;
    logic              w_ready;
    logic              next_block;
    logic [31:0]       w_t;
    logic              w_valid;
    logic [5:0]        round;
    logic [BIDX_W-1:0] block_idx;
    logic              block_first;
    logic              block_last;
    logic              busy;
    logic              done;
`ifdef SCHED_CHKSUM_EN
    logic [31:0]       w_sum;

    modport master (
        output start, processed_msg, num_blocks_m1, w_ready, next_block,
        input  w_t, w_valid, round, block_idx, block_first, block_last,
               busy, done, w_sum
    );

    modport slave (
        input  start, processed_msg, num_blocks_m1, w_ready, next_block,
        output w_t, w_valid, round, block_idx, block_first, block_last,
               busy, done, w_sum
    );
`else
    modport master (
        output start, processed_msg, num_blocks_m1, w_ready, next_block,
        input  w_t, w_valid, round, block_idx, block_first, block_last,
               busy, done
    );

    modport slave (
        input  start, processed_msg, num_blocks_m1, w_ready, next_block,
        output w_t, w_valid, round, block_idx, block_first, block_last,
               busy, done
    );
`endif
endinterface

// File: rtl/sha256_msg_scheduler.sv
// -----------------------------------------------------------------------------
// sha256_msg_scheduler
// Captures a padded message of up to NUM_BLK_MAX 512-bit blocks and, for each
// block, streams the ROUNDS expanded SHA-256 schedule words to the
// compression core over a valid/ready handshake. Multi-block messages pause
// between blocks until the core pulses next_block.
//
// Ports:
//   clk    : clock
//   n_rst  : asynchronous active-low reset
//   bus    : sha256_msg_scheduler_if.slave (request, release and word stream)
//
// Optional feature macro: SCHED_CHKSUM_EN
//   When defined, bus.w_sum carries the mod-2^32 sum of all words transferred
//   in the current block (cleared on block load, held until the next load).
//
// Implementation notes:
//   A 16-word sliding window holds W[t..t+15]; w_t is always window[0], so
//   w_t and w_valid come straight from registers and never depend on
//   w_ready combinationally. Each transfer shifts the window and appends
//   W[t+16], computed from the current window.
// -----------------------------------------------------------------------------
module sha256_msg_scheduler #(
    parameter int NUM_BLK_MAX = 4,
    parameter int ROUNDS      = 64
) (
    input logic                   clk,
    input logic                   n_rst,
    sha256_msg_scheduler_if.slave bus
);
    localparam int         MSG_W      = 512 * NUM_BLK_MAX;
    localparam int         BIDX_W     = (NUM_BLK_MAX > 1) ? $clog2(NUM_BLK_MAX) : 1;
    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_STREAM    = 3'd2;
    localparam logic [2:0] S_WAIT_NEXT = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [MSG_W-1:0]  msg_q;
    logic [BIDX_W-1:0] nblk_q;
    logic [BIDX_W-1:0] block_idx_q;
    logic [5:0]        round_q;
    logic [31:0]       win_q [16];

    logic [511:0]      blk_data [NUM_BLK_MAX];
    logic [511:0]      cur_blk;
    logic [31:0]       blk_word [16];
    logic [31:0]       w_next;
    logic              xfer;
    logic              last_round;
    logic              last_block;

    // Block k sits at the top of the message, most-significant block first.
    generate
        for (genvar gi = 0; gi < NUM_BLK_MAX; gi++) begin : g_blk
            assign blk_data[gi] = msg_q[MSG_W-1-512*gi -: 512];
        end
    endgenerate

    assign cur_blk = blk_data[block_idx_q];

    // Word j of a block is big-endian within the block: word 0 is the MSBs.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_word
            assign blk_word[gi] = cur_blk[511-32*gi -: 32];
        end
    endgenerate

    // Window holds W[t..t+15]: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
    assign w_next = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

    assign xfer       = (state_q == S_STREAM) && bus.w_ready;
    assign last_round = (round_q == LAST_ROUND);
    assign last_block = (block_idx_q == nblk_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (xfer && last_round) begin
                    state_d = last_block ? S_DONE : S_WAIT_NEXT;
                end
            end
            S_WAIT_NEXT: begin
                if (bus.next_block) begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            msg_q       <= '0;
            nblk_q      <= '0;
            block_idx_q <= '0;
            round_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        msg_q       <= bus.processed_msg;
                        nblk_q      <= bus.num_blocks_m1;
                        block_idx_q <= '0;
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < 16; i++) begin
                        win_q[i] <= blk_word[i];
                    end
                    round_q <= '0;
                end
                S_STREAM: begin
                    if (xfer) begin
                        for (int i = 0; i < 15; i++) begin
                            win_q[i] <= win_q[i+1];
                        end
                        win_q[15] <= w_next;
                        round_q   <= round_q + 6'd1;
                        // Advance the block pointer as the block ends so
                        // WAIT_NEXT already shows the upcoming block.
                        if (last_round && !last_block) begin
                            block_idx_q <= block_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SCHED_CHKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sum_q <= '0;
        end else if (state_q == S_LOAD) begin
            sum_q <= '0;
        end else if (xfer) begin
            sum_q <= sum_q + win_q[0];
        end
    end

    assign bus.w_sum = sum_q;
`endif

    assign bus.w_t         = win_q[0];
    assign bus.w_valid     = (state_q == S_STREAM);
    assign bus.round       = round_q;
    assign bus.block_idx   = block_idx_q;
    assign bus.block_first = (state_q == S_STREAM) && (round_q == 6'd0);
    // Gated by busy so every output reads 0 after reset.
    assign bus.block_last  = (state_q != S_IDLE) && last_block;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_scheduler
// Self-checking bench for sha256_msg_scheduler. Expected schedule words come
// from a straightforward 64-entry reference expansion pushed to a queue when
// a message is launched; each accepted word pops and compares.
// Define SCHED_CHKSUM_EN for both bench and RTL to exercise w_sum.
// -----------------------------------------------------------------------------
module tb_sha256_msg_scheduler;
    logic clk;
    logic n_rst;

    sha256_msg_scheduler_if bus ();

    sha256_msg_scheduler dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q [$];
    logic [31:0] exp_sum;

    logic        obs_valid;
    logic [31:0] obs_wt;
    logic [5:0]  obs_round;
    logic        obs_first;
    logic        obs_last;
    logic [1:0]  obs_bidx;
    logic        obs_xfer;

    logic [511:0] abc_blk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference expansion using the full W[0..63] array.
    task automatic push_block(input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] s0;
        logic [31:0] s1;
        exp_sum = 32'h0;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                w[t] = blk[511-32*t -: 32];
            end else begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
            exp_sum = exp_sum + w[t];
            exp_q.push_back(w[t]);
        end
    endtask

    function automatic logic [44:0] all_outs();
        return {bus.w_t, bus.w_valid, bus.round, bus.block_idx,
                bus.block_first, bus.block_last, bus.busy, bus.done};
    endfunction

    // Called at a falling edge: sample outputs, drive w_ready for the next
    // rising edge, then advance to the following falling edge.
    task automatic step(input bit rdy);
        obs_valid = bus.w_valid;
        obs_wt    = bus.w_t;
        obs_round = bus.round;
        obs_first = bus.block_first;
        obs_last  = bus.block_last;
        obs_bidx  = bus.block_idx;
        bus.w_ready = rdy;
        obs_xfer  = obs_valid && rdy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (all_outs() !== 45'h0) begin
            fails++;
            $display("FAIL reset_outs got=%h exp=0", all_outs());
        end
`ifdef SCHED_CHKSUM_EN
        tests++;
        if (bus.w_sum !== 32'h0) begin
            fails++;
            $display("FAIL reset_wsum got=%h exp=0", bus.w_sum);
        end
`endif
        n_rst = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_abc();
        int cnt;
        logic [31:0] e;
        logic [31:0] kv [6];
        int          kr [6];
        kv = '{32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000, 32'h7DA86405, 32'h12B1EDEB};
        kr = '{0, 15, 16, 17, 18, 63};
        exp_q.delete();
        bus.processed_msg = {abc_blk, 1536'h0};
        bus.num_blocks_m1 = 2'd0;
        push_block(abc_blk);
        bus.w_ready = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if (bus.w_valid !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL abc_load valid=%b busy=%b exp valid=0 busy=1", bus.w_valid, bus.busy);
        end
        @(negedge clk);
        tests++;
        if (bus.w_valid !== 1'b1 || bus.block_first !== 1'b1) begin
            fails++;
            $display("FAIL abc_latency valid=%b first=%b exp 1 1", bus.w_valid, bus.block_first);
        end
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 64; c++) begin
            step(1'b1);
            if (obs_xfer) begin
                e = exp_q.pop_front();
                $display("[TB] abc t=%0d w_t=%h", obs_round, obs_wt);
                tests++;
                if (obs_wt !== e || obs_round !== 6'(cnt) || obs_first !== (cnt == 0)) begin
                    fails++;
                    $display("FAIL abc_word t=%0d got w=%h r=%0d f=%b exp w=%h r=%0d f=%b",
                             cnt, obs_wt, obs_round, obs_first, e, cnt, (cnt == 0));
                end
                for (int k = 0; k < 6; k++) begin
                    if (kr[k] == cnt) begin
                        tests++;
                        if (obs_wt !== kv[k]) begin
                            fails++;
                            $display("FAIL abc_const W%0d got=%h exp=%h", cnt, obs_wt, kv[k]);
                        end
                    end
                end
`ifdef SCHED_CHKSUM_EN
                if (cnt == 0) begin
                    tests++;
                    if (bus.w_sum !== 32'h61626380) begin
                        fails++;
                        $display("FAIL abc_wsum_first got=%h exp=61626380", bus.w_sum);
                    end
                end
`endif
                cnt++;
            end
        end
        tests++;
        if (cnt != 64) begin
            fails++;
            $display("FAIL abc_count got=%0d exp=64", cnt);
        end
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.w_valid !== 1'b0) begin
            fails++;
            $display("FAIL abc_done done=%b busy=%b valid=%b exp 1 1 0", bus.done, bus.busy, bus.w_valid);
        end
`ifdef SCHED_CHKSUM_EN
        tests++;
        if (bus.w_sum !== exp_sum) begin
            fails++;
            $display("FAIL abc_wsum_final got=%h exp=%h", bus.w_sum, exp_sum);
        end
`endif
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL abc_done_pulse done=%b busy=%b exp 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_random_ready();
        int cnt;
        bit rdy;
        bit held;
        logic [31:0] h_wt;
        logic [5:0]  h_rnd;
        logic [31:0] e;
        exp_q.delete();
        push_block(abc_blk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        held = 1'b0;
        h_wt = '0;
        h_rnd = '0;
        for (int c = 0; c < 1000 && cnt < 64; c++) begin
            rdy = 1'($urandom_range(0, 1));
            step(rdy);
            if (held) begin
                tests++;
                if (obs_wt !== h_wt || obs_round !== h_rnd || obs_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL stall_hold got w=%h r=%0d v=%b exp w=%h r=%0d v=1",
                             obs_wt, obs_round, obs_valid, h_wt, h_rnd);
                end
            end
            held  = obs_valid && !rdy;
            h_wt  = obs_wt;
            h_rnd = obs_round;
            if (obs_xfer) begin
                e = exp_q.pop_front();
                tests++;
                if (obs_wt !== e || obs_round !== 6'(cnt)) begin
                    fails++;
                    $display("FAIL rand_word t=%0d got w=%h r=%0d exp w=%h", cnt, obs_wt, obs_round, e);
                end
                cnt++;
            end
        end
        tests++;
        if (cnt != 64 || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL rand_count got=%0d done=%b exp=64 done=1", cnt, bus.done);
        end
        step(1'b1);
    endtask

    task automatic test_two_blocks();
        int cnt;
        logic [511:0] b1;
        logic [31:0] e;
        for (int i = 0; i < 16; i++) begin
            b1[32*i +: 32] = $urandom();
        end
        exp_q.delete();
        bus.processed_msg = {abc_blk, b1, 1024'h0};
        bus.num_blocks_m1 = 2'd1;
        push_block(abc_blk);
        push_block(b1);
        bus.w_ready = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            if (b == 1) begin
                tests++;
                if (bus.w_valid !== 1'b0 || bus.block_idx !== 2'd1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL wait_enter valid=%b idx=%0d done=%b busy=%b exp 0 1 0 1",
                             bus.w_valid, bus.block_idx, bus.done, bus.busy);
                end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    tests++;
                    if (bus.w_valid !== 1'b0 || bus.busy !== 1'b1) begin
                        fails++;
                        $display("FAIL wait_hold k=%0d valid=%b busy=%b exp 0 1", k, bus.w_valid, bus.busy);
                    end
                end
                bus.next_block = 1'b1;
                @(negedge clk);
                bus.next_block = 1'b0;
                tests++;
                if (bus.w_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL blk1_load valid=%b exp=0", bus.w_valid);
                end
                @(negedge clk);
                tests++;
                if (bus.w_valid !== 1'b1 || bus.round !== 6'd0 || bus.block_first !== 1'b1) begin
                    fails++;
                    $display("FAIL blk1_latency valid=%b round=%0d first=%b exp 1 0 1",
                             bus.w_valid, bus.round, bus.block_first);
                end
            end
            cnt = 0;
            for (int c = 0; c < 200 && cnt < 64; c++) begin
                // next_block coinciding with the final transfer must be dropped
                bus.next_block = (b == 0) && bus.w_valid && (bus.round == 6'd63);
                step(1'b1);
                if (obs_xfer) begin
                    e = exp_q.pop_front();
                    tests++;
                    if (obs_wt !== e || obs_bidx !== 2'(b) || obs_last !== (b == 1)) begin
                        fails++;
                        $display("FAIL blk_word b=%0d t=%0d got w=%h idx=%0d last=%b exp w=%h idx=%0d last=%b",
                                 b, cnt, obs_wt, obs_bidx, obs_last, e, b, (b == 1));
                    end
                    cnt++;
                end
            end
            bus.next_block = 1'b0;
            tests++;
            if (cnt != 64) begin
                fails++;
                $display("FAIL blk_count b=%0d got=%0d exp=64", b, cnt);
            end
        end
        tests++;
        if (bus.done !== 1'b1) begin
            fails++;
            $display("FAIL two_done got=%b exp=1", bus.done);
        end
        step(1'b1);
    endtask

    task automatic test_ignore();
        int cnt;
        logic [31:0] e;
        exp_q.delete();
        bus.processed_msg = {abc_blk, 1536'h0};
        bus.num_blocks_m1 = 2'd0;
        push_block(abc_blk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 64; c++) begin
            if (cnt == 10) begin
                bus.start = 1'b1;
                for (int i = 0; i < 64; i++) begin
                    bus.processed_msg[32*i +: 32] = $urandom();
                end
                bus.num_blocks_m1 = 2'd3;
            end
            step(1'b1);
            bus.start = 1'b0;
            if (obs_xfer) begin
                e = exp_q.pop_front();
                tests++;
                if (obs_wt !== e) begin
                    fails++;
                    $display("FAIL ign_word t=%0d got=%h exp=%h", cnt, obs_wt, e);
                end
                cnt++;
            end
        end
        tests++;
        if (cnt != 64 || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL ign_done cnt=%0d done=%b exp 64 1", cnt, bus.done);
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL ign_start_done k=%0d busy=%b exp=0", k, bus.busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int cnt;
        int c;
        logic [31:0] e;
        exp_q.delete();
        bus.processed_msg = {abc_blk, 1536'h0};
        bus.num_blocks_m1 = 2'd0;
        push_block(abc_blk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        c = 0;
        while (!(bus.w_valid && bus.round == 6'd30) && c < 100) begin
            step(1'b1);
            c++;
        end
        tests++;
        if (c >= 100) begin
            fails++;
            $display("FAIL abort_reach round=%0d exp=30", bus.round);
        end
        #2 n_rst = 1'b0;
        #1;
        tests++;
        if (all_outs() !== 45'h0) begin
            fails++;
            $display("FAIL abort_async got=%h exp=0", all_outs());
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_quiet k=%0d done=%b busy=%b exp 0 0", k, bus.done, bus.busy);
            end
        end
        exp_q.delete();
        push_block(abc_blk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 200 && cnt < 64; k++) begin
            step(1'b1);
            if (obs_xfer) begin
                e = exp_q.pop_front();
                tests++;
                if (obs_wt !== e || obs_round !== 6'(cnt)) begin
                    fails++;
                    $display("FAIL restart_word t=%0d got w=%h r=%0d exp w=%h", cnt, obs_wt, obs_round, e);
                end
                cnt++;
            end
        end
        tests++;
        if (cnt != 64 || bus.done !== 1'b1) begin
            fails++;
            $display("FAIL restart_done cnt=%0d done=%b exp 64 1", cnt, bus.done);
        end
        step(1'b1);
    endtask

    initial begin
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        n_rst = 1'b0;
        bus.start = 1'b0;
        bus.processed_msg = '0;
        bus.num_blocks_m1 = '0;
        bus.w_ready = 1'b0;
        bus.next_block = 1'b0;
        @(negedge clk);
        test_reset();
        test_abc();
        test_random_ready();
        test_two_blocks();
        test_ignore();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
